// File: rtl/cda_pkg.sv
// Shared definitions for the cda UART transmitter.
//   state_t          - transmitter FSM states
//   DATA_BITS        - payload bits per frame
//   CLKS_PER_BIT_DEF - default bit period (50 MHz / 115200)
package cda_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam int DATA_BITS        = 8;
  localparam int CLKS_PER_BIT_DEF = 434;

endpackage

// File: rtl/cda_baud_tick.sv
// Bit-period timer for the UART transmitter.
// Counts 0..CLKS_PER_BIT-1 while enabled and is held at zero otherwise.
// bit_tick is high during the last cycle of each bit period, so the
// consumer advances on the edge that ends the bit.
//   clk      in  system clock
//   rst      in  asynchronous active-high reset
//   en       in  count enable (frame in progress)
//   bit_tick out last cycle of the current bit period
module cda_baud_tick #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic bit_tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!en) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bit_tick = en && (cnt == LAST);

endmodule

// File: rtl/cda_uart_tx.sv
// UART transmitter: 8N1, or 8E1 when PARITY_EN=1, LSB first.
// A byte is accepted on the edge where tx_valid && tx_ready; the frame then
// runs start, 8 data bits, optional even parity and stop, each bit lasting
// CLKS_PER_BIT cycles. All outputs are registered.
//   clk        in  system clock
//   rst        in  asynchronous active-high reset
//   tx_data    in  byte to send, sampled only on the accept edge
//   tx_valid   in  upstream has a byte
//   tx_ready   out block can accept a byte this cycle (IDLE only)
//   tx         out serial line, idles high
//   busy       out frame in progress
//   frame_done out one-cycle pulse after the stop bit ends
module cda_uart_tx
  import cda_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int PARITY_EN    = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  state_t     state;
  logic [2:0] bit_idx;
  logic [7:0] shift;
  logic       parity;
  logic       bit_tick;
  logic       accept;

  assign accept = tx_valid && tx_ready;

  // The timer runs only while busy, so it restarts from zero on every accept.
  cda_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .en      (busy),
    .bit_tick(bit_tick)
  );

  // Payload registers carry no reset: they are always reloaded on accept
  // before anything reads them.
  always_ff @(posedge clk) begin
    if (accept) begin
      shift  <= tx_data;
      parity <= ^tx_data;
    end else if (state == DATA && bit_tick) begin
      shift <= {1'b0, shift[7:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      tx         <= 1'b1;
      tx_ready   <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      bit_idx    <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state    <= START;
            tx       <= 1'b0;
            tx_ready <= 1'b0;
            busy     <= 1'b1;
            bit_idx  <= '0;
          end
        end
        START: begin
          if (bit_tick) begin
            state <= DATA;
            tx    <= shift[0];
          end
        end
        DATA: begin
          if (bit_tick) begin
            if (bit_idx == LAST_BIT) begin
              bit_idx <= '0;
              if (PARITY_EN != 0) begin
                state <= PARITY;
                tx    <= parity;
              end else begin
                state <= STOP;
                tx    <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + 1'b1;
              // shift[1] is the bit that becomes shift[0] on this same edge.
              tx      <= shift[1];
            end
          end
        end
        PARITY: begin
          if (bit_tick) begin
            state <= STOP;
            tx    <= 1'b1;
          end
        end
        STOP: begin
          if (bit_tick) begin
            state      <= IDLE;
            tx         <= 1'b1;
            frame_done <= 1'b1;
            tx_ready   <= 1'b1;
            busy       <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          tx       <= 1'b1;
          tx_ready <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
